adma_dm_rd_arb: RTL and testbench

//  Shares the DMA read host (AR + R engine) among DMA_CHN_NUM channel requesters. Each cycle a

---
 rtl/adma_dm_pkg.sv | 41 ++++
 rtl/adma_dm_rd_arb_if.sv | 45 ++++
 rtl/adma_rr_arb.sv | 43 ++++
 rtl/adma_dm_rd_arb.sv | 111 +++++++++++
 tb/tb_adma_dm_rd_arb.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/adma_dm_pkg.sv
// ---------------------------------------------------------------------------
// adma_dm_pkg
// Shared geometry and types for the DMA read-host arbiter slice.
//   DMA_CHN_NUM   number of requesting channels (>=2)
//   SRC_ADDR_W    source address width
//   MST_ID_W      AXI ID width
//   ATX_LEN_W     AXI burst length width
//   OSTD_PER_CHN  max outstanding reads per channel (>=1)
// The arbiter, its interface and the bench all take their widths from here,
// so this package is the single place to re-size the block.
// ---------------------------------------------------------------------------
package adma_dm_pkg;

    localparam int DMA_CHN_NUM  = 4;
    localparam int SRC_ADDR_W   = 32;
    localparam int MST_ID_W     = 5;
    localparam int ATX_LEN_W    = 8;
    localparam int OSTD_PER_CHN = 2;

    localparam int CHN_IDX_W  = (DMA_CHN_NUM > 1) ? $clog2(DMA_CHN_NUM) : 1;
    localparam int OSTD_CNT_W = $clog2(OSTD_PER_CHN + 1);

    typedef logic [CHN_IDX_W-1:0]  chn_idx_t;
    typedef logic [OSTD_CNT_W-1:0] ostd_cnt_t;

    typedef struct packed {
        logic [MST_ID_W-1:0]   id;
        logic [SRC_ADDR_W-1:0] addr;
        logic [ATX_LEN_W-1:0]  len;
        logic [1:0]            burst;
    } rd_atx_t;

    // Round-robin pointer advance: one past the winner, wrapping N-1 -> 0.
    function automatic chn_idx_t next_ptr(input chn_idx_t i_win);
        if (int'(i_win) == DMA_CHN_NUM - 1) begin
            return '0;
        end
        return i_win + 1'b1;
    endfunction

endpackage

// File: rtl/adma_dm_rd_arb_if.sv
// ---------------------------------------------------------------------------
// adma_dm_rd_arb_if
// Bundles the per-channel request side and the read-host transaction side of
// the arbiter.
//   chn_req_vld/rdy   per-channel request handshake (rdy one-hot or zero)
//   chn_arid/araddr/arlen/arburst   per-channel transaction fields
//   chn_done          per-channel pulse: one read fully returned
//   atx_*             registered transaction presented to the read host
//   atx_vld/atx_rdy   host-side handshake
//   arb_busy          reads in flight or a transaction held
// Modports: master = arbiter, slave = channels + read host environment.
// ---------------------------------------------------------------------------
interface adma_dm_rd_arb_if;
    import adma_dm_pkg::*;

    logic [DMA_CHN_NUM-1:0] chn_req_vld;
    logic [DMA_CHN_NUM-1:0] chn_req_rdy;
    logic [MST_ID_W-1:0]    chn_arid    [DMA_CHN_NUM];
    logic [SRC_ADDR_W-1:0]  chn_araddr  [DMA_CHN_NUM];
    logic [ATX_LEN_W-1:0]   chn_arlen   [DMA_CHN_NUM];
    logic [1:0]             chn_arburst [DMA_CHN_NUM];
    logic [DMA_CHN_NUM-1:0] chn_done;

    chn_idx_t               atx_chn_id;
    logic [MST_ID_W-1:0]    atx_arid;
    logic [SRC_ADDR_W-1:0]  atx_araddr;
    logic [ATX_LEN_W-1:0]   atx_arlen;
    logic [1:0]             atx_arburst;
    logic                   atx_vld;
    logic                   atx_rdy;
    logic                   arb_busy;

    modport master (
        input  chn_req_vld, chn_arid, chn_araddr, chn_arlen, chn_arburst, chn_done, atx_rdy,
        output chn_req_rdy, atx_chn_id, atx_arid, atx_araddr, atx_arlen, atx_arburst,
               atx_vld, arb_busy
    );

    modport slave (
        output chn_req_vld, chn_arid, chn_araddr, chn_arlen, chn_arburst, chn_done, atx_rdy,
        input  chn_req_rdy, atx_chn_id, atx_arid, atx_araddr, atx_arlen, atx_arburst,
               atx_vld, arb_busy
    );

endinterface

// File: rtl/adma_rr_arb.sv
// ---------------------------------------------------------------------------
// adma_rr_arb
// Combinational N-way round-robin picker. The search starts at i_ptr and
// wraps modulo N; the first requesting position wins.
//   i_req   [N-1:0]  request vector
//   i_ptr   [IW-1:0] search start position (must be < N)
//   o_gnt   [N-1:0]  one-hot grant (zero when nothing requests)
//   o_idx   [IW-1:0] index of the granted position
//   o_any            some position was granted
// ---------------------------------------------------------------------------
module adma_rr_arb #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);

    int w_pos;

    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        w_pos = 0;
        for (int k = 0; k < N; k++) begin
            // Rotated position without a modulo operator.
            w_pos = int'(i_ptr) + k;
            if (w_pos >= N) begin
                w_pos = w_pos - N;
            end
            if (!o_any && i_req[w_pos]) begin
                o_any        = 1'b1;
                o_gnt[w_pos] = 1'b1;
                o_idx        = IW'(w_pos);
            end
        end
    end

endmodule

// File: rtl/adma_dm_rd_arb.sv
// ---------------------------------------------------------------------------
// adma_dm_rd_arb
// Shares the DMA read host among DMA_CHN_NUM channel requesters. Each cycle
// the output stage can load, the round-robin winner among eligible channels
// (valid and below OSTD_PER_CHN reads in flight) is registered and presented
// on atx_*, and that channel sees chn_req_rdy in the same cycle.
//   clk   clock
//   rst   synchronous reset, active-high
//   bus   adma_dm_rd_arb_if.master (channel requests, host transaction port)
// ---------------------------------------------------------------------------
module adma_dm_rd_arb
    import adma_dm_pkg::*;
(
    input logic              clk,
    input logic              rst,
    adma_dm_rd_arb_if.master bus
);

    localparam int N = DMA_CHN_NUM;

    // Control state
    chn_idx_t  r_ptr;
    ostd_cnt_t r_cnt [N];
    logic      r_vld_p1;

    // Output stage data
    rd_atx_t   r_atx_p1;
    chn_idx_t  r_chn_p1;

    logic [N-1:0] w_elig;
    logic [N-1:0] w_gnt;
    logic [N-1:0] w_rdy;
    chn_idx_t     w_idx;
    logic         w_any;
    logic         w_load;
    logic         w_cnt_nz;

    always_comb begin
        w_elig   = '0;
        w_cnt_nz = 1'b0;
        for (int i = 0; i < N; i++) begin
            w_elig[i] = bus.chn_req_vld[i] && (r_cnt[i] < ostd_cnt_t'(OSTD_PER_CHN));
            w_cnt_nz  = w_cnt_nz | (r_cnt[i] != '0);
        end
    end

    adma_rr_arb #(
        .N  (N),
        .IW (CHN_IDX_W)
    ) u_rr_arb (
        .i_req (w_elig),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_idx),
        .o_any (w_any)
    );

    // The stage can take a new transaction when empty or when the host is
    // accepting the current one this cycle.
    assign w_load = !r_vld_p1 || bus.atx_rdy;

    // Grant is suppressed during reset so no channel believes it was accepted
    // by a transaction that the reset is about to discard.
    assign w_rdy = (w_load && w_any && !rst) ? w_gnt : '0;

    // ---- stage p0 -> p1: winner capture ----
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_p1 <= 1'b0;
            r_ptr    <= '0;
            r_atx_p1 <= '0;
            r_chn_p1 <= '0;
        end else if (w_load) begin
            r_vld_p1 <= w_any;
            if (w_any) begin
                r_atx_p1.id    <= bus.chn_arid[w_idx];
                r_atx_p1.addr  <= bus.chn_araddr[w_idx];
                r_atx_p1.len   <= bus.chn_arlen[w_idx];
                r_atx_p1.burst <= bus.chn_arburst[w_idx];
                r_chn_p1       <= w_idx;
                r_ptr          <= next_ptr(w_idx);
            end
        end
    end

    // Outstanding counters: counted from grant, so the transaction sitting in
    // the output stage already occupies a slot. A done at zero is dropped.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (rst) begin
                r_cnt[i] <= '0;
            end else begin
                case ({w_rdy[i], bus.chn_done[i] && (r_cnt[i] != '0)})
                    2'b10:   r_cnt[i] <= r_cnt[i] + 1'b1;
                    2'b01:   r_cnt[i] <= r_cnt[i] - 1'b1;
                    default: r_cnt[i] <= r_cnt[i];
                endcase
            end
        end
    end

    assign bus.chn_req_rdy = w_rdy;
    assign bus.atx_vld     = r_vld_p1;
    assign bus.atx_chn_id  = r_chn_p1;
    assign bus.atx_arid    = r_atx_p1.id;
    assign bus.atx_araddr  = r_atx_p1.addr;
    assign bus.atx_arlen   = r_atx_p1.len;
    assign bus.atx_arburst = r_atx_p1.burst;
    assign bus.arb_busy    = r_vld_p1 | w_cnt_nz;

endmodule

// File: tb/tb_adma_dm_rd_arb.sv
module tb_adma_dm_rd_arb;
    import adma_dm_pkg::*;

    logic clk;
    logic rst;

    adma_dm_rd_arb_if bus ();

    adma_dm_rd_arb dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: channel counts, rotation start, held transaction.
    int          m_cnt [4];
    int          m_ptr;
    bit          m_vld;
    int          m_chn;
    logic [63:0] m_id, m_addr, m_len, m_burst;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, check outputs against the model mid-cycle,
    // then advance the model with what the clock edge should do.
    task automatic cycle(input logic [3:0] vld, input logic [3:0] done, input logic ardy,
                         output logic [3:0] rdy_obs);
        bit          load, found;
        int          w, c, busy;
        logic [3:0]  exp_rdy;
        bus.chn_req_vld = vld;
        bus.chn_done    = done;
        bus.atx_rdy     = ardy;
        for (int i = 0; i < 4; i++) begin
            bus.chn_arid[i]    = 5'($urandom);
            bus.chn_araddr[i]  = $urandom;
            bus.chn_arlen[i]   = 8'($urandom);
            bus.chn_arburst[i] = 2'($urandom);
        end
        @(negedge clk);
        load  = !m_vld || ardy;
        found = 0;
        w     = 0;
        if (!rst && load) begin
            for (int k = 0; k < 4; k++) begin
                c = (m_ptr + k) % 4;
                if (!found && vld[c] && m_cnt[c] < OSTD_PER_CHN) begin
                    found = 1;
                    w     = c;
                end
            end
        end
        exp_rdy = found ? (4'b0001 << w) : 4'b0000;
        busy = m_vld ? 1 : 0;
        for (int i = 0; i < 4; i++) if (m_cnt[i] > 0) busy = 1;
        chk("chn_req_rdy", bus.chn_req_rdy, exp_rdy);
        chk("atx_vld", bus.atx_vld, m_vld);
        chk("arb_busy", bus.arb_busy, busy[0]);
        if (m_vld) begin
            chk("atx_chn_id", bus.atx_chn_id, m_chn);
            chk("atx_arid", bus.atx_arid, m_id);
            chk("atx_araddr", bus.atx_araddr, m_addr);
            chk("atx_arlen", bus.atx_arlen, m_len);
            chk("atx_arburst", bus.atx_arburst, m_burst);
        end
        rdy_obs = bus.chn_req_rdy;
        if (rst) begin
            for (int i = 0; i < 4; i++) m_cnt[i] = 0;
            m_ptr = 0;
            m_vld = 0;
        end else begin
            if (load) begin
                if (found) begin
                    m_vld   = 1;
                    m_chn   = w;
                    m_id    = 64'(bus.chn_arid[w]);
                    m_addr  = 64'(bus.chn_araddr[w]);
                    m_len   = 64'(bus.chn_arlen[w]);
                    m_burst = 64'(bus.chn_arburst[w]);
                    m_ptr   = (w + 1) % 4;
                end else begin
                    m_vld = 0;
                end
            end
            for (int i = 0; i < 4; i++) begin
                if (exp_rdy[i]) m_cnt[i]++;
                if (done[i] && m_cnt[i] > 0 && !exp_rdy[i]) m_cnt[i]--;
                else if (done[i] && exp_rdy[i] && m_cnt[i] > 1) m_cnt[i]--;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        logic [3:0] r;
        rst = 1'b1;
        cycle(4'b0000, 4'b0000, 1'b0, r);
        rst = 1'b0;
    endtask

    initial begin
        logic [3:0]  r;
        logic [31:0] h_addr;
        logic [4:0]  h_id;
        logic [7:0]  h_len;
        logic [1:0]  h_burst;
        logic [1:0]  h_chn;
        logic [3:0]  d;
        for (int i = 0; i < 4; i++) m_cnt[i] = 0;
        m_ptr = 0; m_vld = 0; m_chn = 0;
        m_id = 0; m_addr = 0; m_len = 0; m_burst = 0;
        bus.chn_req_vld = '0;
        bus.chn_done    = '0;
        bus.atx_rdy     = 1'b0;

        // Reset state
        rst = 1'b1;
        cycle(4'b1111, 4'b0000, 1'b1, r);
        chk("rst_rdy", r, 4'b0000);
        cycle(4'b0000, 4'b0000, 1'b0, r);
        rst = 1'b0;
        chk("rst_araddr", bus.atx_araddr, 0);
        chk("rst_arid", bus.atx_arid, 0);
        chk("rst_arlen", bus.atx_arlen, 0);
        chk("rst_arburst", bus.atx_arburst, 0);
        chk("rst_chn_id", bus.atx_chn_id, 0);
        chk("rst_vld", bus.atx_vld, 0);

        // All channels requesting, host always ready: 0,1,2,3 twice, then limit
        for (int k = 0; k < 8; k++) begin
            cycle(4'b1111, 4'b0000, 1'b1, r);
            chk("t1_grant", r, 4'b0001 << (k % 4));
            if (k == 0) chk("t1_latency", bus.atx_vld, 1'b1);
        end
        cycle(4'b1111, 4'b0000, 1'b1, r);
        chk("t1_ostd_limit", r, 4'b0000);
        do_reset();

        // Single channel: two grants, blocked, one done frees one slot
        for (int k = 0; k < 4; k++) begin
            cycle(4'b0100, 4'b0000, 1'b1, r);
            chk("t2_grant", r, (k < 2) ? 4'b0100 : 4'b0000);
        end
        cycle(4'b0100, 4'b0100, 1'b1, r);
        chk("t2_done_cycle", r, 4'b0000);
        cycle(4'b0100, 4'b0000, 1'b1, r);
        chk("t2_third_grant", r, 4'b0100);
        cycle(4'b0100, 4'b0000, 1'b1, r);
        chk("t2_blocked_again", r, 4'b0000);
        do_reset();

        // Host stall: held fields stable, no grants, then next winner loads
        cycle(4'b0011, 4'b0000, 1'b1, r);
        chk("t3_first", r, 4'b0001);
        h_addr = bus.atx_araddr; h_id = bus.atx_arid; h_len = bus.atx_arlen;
        h_burst = bus.atx_arburst; h_chn = bus.atx_chn_id;
        for (int k = 0; k < 5; k++) begin
            cycle(4'b0011, 4'b0000, 1'b0, r);
            chk("t3_hold_rdy", r, 4'b0000);
            chk("t3_hold_addr", bus.atx_araddr, h_addr);
            chk("t3_hold_id", bus.atx_arid, h_id);
            chk("t3_hold_len", bus.atx_arlen, h_len);
            chk("t3_hold_burst", bus.atx_arburst, h_burst);
            chk("t3_hold_chn", bus.atx_chn_id, h_chn);
        end
        cycle(4'b0011, 4'b0000, 1'b1, r);
        chk("t3_release", r, 4'b0010);
        chk("t3_next_chn", bus.atx_chn_id, 1);
        do_reset();

        // Simultaneous grant and done keeps the count; done at zero is ignored
        cycle(4'b0010, 4'b0000, 1'b1, r);
        chk("t4_g1", r, 4'b0010);
        cycle(4'b0010, 4'b0010, 1'b1, r);
        chk("t4_g_and_done", r, 4'b0010);
        cycle(4'b0010, 4'b0000, 1'b1, r);
        chk("t4_g3", r, 4'b0010);
        cycle(4'b0010, 4'b0000, 1'b1, r);
        chk("t4_full", r, 4'b0000);
        cycle(4'b0000, 4'b1000, 1'b1, r);
        for (int k = 0; k < 3; k++) begin
            cycle(4'b1000, 4'b0000, 1'b1, r);
            chk("t4_ch3", r, (k < 2) ? 4'b1000 : 4'b0000);
        end
        do_reset();

        // Pointer at 3: ch3 wins over ch0, then pointer wraps to ch0
        cycle(4'b0100, 4'b0000, 1'b1, r);
        chk("t5_setup", r, 4'b0100);
        cycle(4'b1001, 4'b0000, 1'b1, r);
        chk("t5_ch3", r, 4'b1000);
        cycle(4'b1001, 4'b0000, 1'b1, r);
        chk("t5_wrap_ch0", r, 4'b0001);

        // Reset mid-operation
        chk("t6_pre_vld", bus.atx_vld, 1'b1);
        rst = 1'b1;
        cycle(4'b1111, 4'b0000, 1'b0, r);
        chk("t6_rst_rdy", r, 4'b0000);
        rst = 1'b0;
        chk("t6_vld", bus.atx_vld, 1'b0);
        chk("t6_busy", bus.arb_busy, 1'b0);
        cycle(4'b1110, 4'b0000, 1'b1, r);
        cycle(4'b1111, 4'b0000, 1'b1, r);
        do_reset();
        cycle(4'b1111, 4'b0000, 1'b1, r);
        chk("t6_first_ch0", r, 4'b0001);
        do_reset();

        // Randomized traffic against the model
        for (int k = 0; k < 400; k++) begin
            d = '0;
            for (int i = 0; i < 4; i++) begin
                if (m_cnt[i] > 0 && $urandom_range(0, 2) == 0) d[i] = 1'b1;
            end
            cycle(4'($urandom), d, ($urandom_range(0, 3) != 0), r);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
